// File: rtl/sha3_absorb_buffer.sv
// SHA3-256 absorb front end: packs 64-bit host words into 17-lane rate blocks,
// applies pad10*1 (0x06..0x80) and hands each block to the Keccak core over valid/ready.
//
// state  | meaning
// FILL   | accepting host words into lane[cnt]
// HOLD   | block presented on blk_data, waiting for blk_ready
// PADBLK | pure padding block presented (message ended exactly on a block boundary)
module sha3_absorb_buffer #(
  parameter int RATE_LANES = 17,
  parameter int DATA_W     = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_isLast,
  input  logic [3:0]                   in_last_bytes,
  output logic                         out_buffer_full,
  output logic                         in_overrun,
  output logic                         blk_valid,
  output logic [RATE_LANES*DATA_W-1:0] blk_data,
  output logic                         blk_first,
  output logic                         blk_last,
  input  logic                         blk_ready
);

  localparam int BLK_W  = RATE_LANES * DATA_W;
  localparam int CNT_W  = $clog2(RATE_LANES + 1);
  localparam int BYTES  = DATA_W / 8;

  typedef enum logic [1:0] {FILL, HOLD, PADBLK} state_t;

  state_t             state_q, state_n;
  logic [BLK_W-1:0]   buf_q, buf_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               first_flag_q, first_flag_n;
  logic               blk_first_q, blk_first_n;
  logic               blk_last_q, blk_last_n;
  logic               pad_pend_q, pad_pend_n;
  logic               overrun_q, overrun_n;

  logic [3:0]         nbytes;
  logic [DATA_W-1:0]  masked_word;
  logic [DATA_W-1:0]  pad_word;
  logic [DATA_W-1:0]  lane_word;
  logic               at_last_lane;
  logic               full_word;

  assign nbytes       = (in_last_bytes > 4'd8) ? 4'd8 : in_last_bytes;
  assign full_word    = (nbytes == 4'd8);
  assign at_last_lane = (cnt_q == CNT_W'(RATE_LANES - 1));

  always_comb begin
    masked_word = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (4'(b) < nbytes) masked_word[b*8 +: 8] = in_data[b*8 +: 8];
    end
  end

  // 0x06 domain byte lands right after the last message byte, inside this lane when it is not full
  assign pad_word  = full_word ? '0 : (DATA_W'(8'h06) << {nbytes[2:0], 3'b000});
  assign lane_word = in_isLast ? (masked_word | pad_word) : in_data;

  always_comb begin
    state_n      = state_q;
    buf_n        = buf_q;
    cnt_n        = cnt_q;
    first_flag_n = first_flag_q;
    blk_first_n  = blk_first_q;
    blk_last_n   = blk_last_q;
    pad_pend_n   = pad_pend_q;
    overrun_n    = overrun_q | (in_valid & (state_q != FILL));

    case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int i = 0; i < RATE_LANES; i++) begin
            if (cnt_q == CNT_W'(i)) buf_n[i*DATA_W +: DATA_W] = lane_word;
            if (in_isLast && full_word && !at_last_lane && (cnt_q + CNT_W'(1) == CNT_W'(i)))
              buf_n[i*DATA_W +: 8] = buf_n[i*DATA_W +: 8] ^ 8'h06;
          end

          if (in_isLast) begin
            state_n     = HOLD;
            cnt_n       = '0;
            blk_first_n = first_flag_q;
            if (at_last_lane && full_word) begin
              // block is pure data; padding goes into a following block
              blk_last_n = 1'b0;
              pad_pend_n = 1'b1;
            end else begin
              buf_n[BLK_W-1 -: 8] = buf_n[BLK_W-1 -: 8] | 8'h80;
              blk_last_n = 1'b1;
              pad_pend_n = 1'b0;
            end
          end else if (at_last_lane) begin
            state_n     = HOLD;
            cnt_n       = '0;
            blk_first_n = first_flag_q;
            blk_last_n  = 1'b0;
            pad_pend_n  = 1'b0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end

      HOLD, PADBLK: begin
        if (blk_ready) begin
          first_flag_n = blk_last_q;
          if (pad_pend_q) begin
            state_n             = PADBLK;
            buf_n               = '0;
            buf_n[7:0]          = 8'h06;
            buf_n[BLK_W-1 -: 8] = 8'h80;
            blk_first_n         = 1'b0;
            blk_last_n          = 1'b1;
            pad_pend_n          = 1'b0;
          end else begin
            state_n     = FILL;
            buf_n       = '0;
            blk_first_n = 1'b0;
            blk_last_n  = 1'b0;
          end
        end
      end

      default: begin
        state_n = FILL;
        buf_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      buf_q        <= '0;
      cnt_q        <= '0;
      first_flag_q <= 1'b1;
      blk_first_q  <= 1'b0;
      blk_last_q   <= 1'b0;
      pad_pend_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_n;
      buf_q        <= buf_n;
      cnt_q        <= cnt_n;
      first_flag_q <= first_flag_n;
      blk_first_q  <= blk_first_n;
      blk_last_q   <= blk_last_n;
      pad_pend_q   <= pad_pend_n;
      overrun_q    <= overrun_n;
    end
  end

  assign blk_valid       = (state_q != FILL);
  assign out_buffer_full = (state_q != FILL);
  assign blk_data        = buf_q;
  assign blk_first       = blk_first_q;
  assign blk_last        = blk_last_q;
  assign in_overrun      = overrun_q;

endmodule

// File: tb/tb_sha3_absorb_buffer.sv
// Scoreboard bench for sha3_absorb_buffer: expected blocks are queued when a message is sent,
// a negedge monitor pops and compares on every blk_valid & blk_ready.
module tb_sha3_absorb_buffer;

  localparam int L  = 17;
  localparam int BW = L * 64;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [63:0]   in_data;
  logic          in_isLast;
  logic [3:0]    in_last_bytes;
  logic          out_buffer_full;
  logic          in_overrun;
  logic          blk_valid;
  logic [BW-1:0] blk_data;
  logic          blk_first;
  logic          blk_last;
  logic          blk_ready;

  typedef struct {
    logic [BW-1:0] data;
    logic          first;
    logic          last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] msg[L];
  int          checks = 0;
  int          errors = 0;

  sha3_absorb_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_isLast       (in_isLast),
    .in_last_bytes   (in_last_bytes),
    .out_buffer_full (out_buffer_full),
    .in_overrun      (in_overrun),
    .blk_valid       (blk_valid),
    .blk_data        (blk_data),
    .blk_first       (blk_first),
    .blk_last        (blk_last),
    .blk_ready       (blk_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < L; i++) begin
        if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
          $display("FAIL %s lane %0d got %h want %h", name, i, act[i*64 +: 64], exp[i*64 +: 64]);
          break;
        end
      end
    end
  endtask

  function automatic logic [BW-1:0] mk_blk(input logic [63:0] l0, input logic [63:0] l1,
                                           input logic [63:0] l16);
    logic [BW-1:0] b;
    b = '0;
    b[63:0]       = l0;
    b[127:64]     = l1;
    b[BW-1 -: 64] = l16;
    return b;
  endfunction

  function automatic logic [BW-1:0] msg_blk(input int nl);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < nl; i++) b[i*64 +: 64] = msg[i];
    return b;
  endfunction

  task automatic push(input logic [BW-1:0] d, input logic f, input logic l);
    exp_t e;
    e.data  = d;
    e.first = f;
    e.last  = l;
    exp_q.push_back(e);
  endtask

  task automatic send_msg(input int nw, input logic [3:0] nb, input bit with_last);
    for (int i = 0; i < nw; i++) begin
      in_valid      = 1'b1;
      in_data       = msg[i];
      in_isLast     = with_last && (i == nw - 1);
      in_last_bytes = (with_last && (i == nw - 1)) ? nb : 4'd0;
      @(posedge clk); #1;
    end
    in_valid      = 1'b0;
    in_isLast     = 1'b0;
    in_data       = '0;
    in_last_bytes = '0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!blk_valid && !out_buffer_full && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout valid=%0b full=%0b pending=%0d", name, blk_valid, out_buffer_full,
               exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block got first=%0b last=%0b want none", blk_first, blk_last);
      end else begin
        mon_e = exp_q.pop_front();
        chk_blk("blk_data", blk_data, mon_e.data);
        chk("blk_first", 64'(blk_first), 64'(mon_e.first));
        chk("blk_last", 64'(blk_last), 64'(mon_e.last));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] abc_blk;
    logic [BW-1:0] empty_blk;
    logic [BW-1:0] pad_blk;
    logic [BW-1:0] b;

    abc_blk   = mk_blk(64'h0000_0000_0663_6261, 64'h0, 64'h8000_0000_0000_0000);
    empty_blk = mk_blk(64'h0000_0000_0000_0006, 64'h0, 64'h8000_0000_0000_0000);
    pad_blk   = empty_blk;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_isLast = 1'b0; in_last_bytes = '0;
    blk_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", 64'(blk_valid), 64'd0);
    chk("rst_full", 64'(out_buffer_full), 64'd0);
    chk("rst_overrun", 64'(in_overrun), 64'd0);
    chk_blk("rst_data", blk_data, '0);
    chk("rst_first", 64'(blk_first), 64'd0);
    chk("rst_last", 64'(blk_last), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" with junk above the valid bytes; full high for exactly one cycle
    blk_ready = 1'b1;
    msg[0] = 64'hDEAD_BEEF_FF63_6261;
    push(abc_blk, 1'b1, 1'b1);
    send_msg(1, 4'd3, 1'b1);
    chk("abc_full_on", 64'(out_buffer_full), 64'd1);
    chk("abc_valid_on", 64'(blk_valid), 64'd1);
    @(posedge clk); #1;
    chk("abc_full_off", 64'(out_buffer_full), 64'd0);
    wait_idle("abc");

    // empty message
    msg[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    push(empty_blk, 1'b1, 1'b1);
    send_msg(1, 4'd0, 1'b1);
    wait_idle("empty");

    // in_last_bytes above 8 behaves as 8: 0x06 spills into lane 1
    msg[0] = 64'h1122_3344_5566_7788;
    push(mk_blk(64'h1122_3344_5566_7788, 64'h06, 64'h8000_0000_0000_0000), 1'b1, 1'b1);
    send_msg(1, 4'd12, 1'b1);
    wait_idle("clamp");

    // 135 bytes: 0x06 and 0x80 share the last byte of lane 16
    for (int i = 0; i < 16; i++) msg[i] = {32'hC0DE_0000 + 32'(i), 32'h1234_5678};
    msg[16] = 64'hFFEE_DDCC_BBAA_9988;
    b = msg_blk(16);
    b[BW-1 -: 64] = 64'h86EE_DDCC_BBAA_9988;
    push(b, 1'b1, 1'b1);
    send_msg(17, 4'd7, 1'b1);
    wait_idle("m135");

    // 136 bytes: full data block followed by a pure pad block, back to back
    msg[16] = 64'h0F1E_2D3C_4B5A_6978;
    push(msg_blk(17), 1'b1, 1'b0);
    push(pad_blk, 1'b0, 1'b1);
    send_msg(17, 4'd8, 1'b1);
    chk("m136_full_c1", 64'(out_buffer_full), 64'd1);
    @(posedge clk); #1;
    chk("m136_full_c2", 64'(out_buffer_full), 64'd1);
    chk("m136_padlast", 64'(blk_last), 64'd1);
    @(posedge clk); #1;
    chk("m136_full_off", 64'(out_buffer_full), 64'd0);
    wait_idle("m136");

    // back-pressure: held block must not change, dropped word raises in_overrun
    chk("pre_overrun", 64'(in_overrun), 64'd0);
    blk_ready = 1'b0;
    msg[0] = 64'h0000_0000_0063_6261;
    push(abc_blk, 1'b1, 1'b1);
    send_msg(1, 4'd3, 1'b1);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_valid = 1'b1; in_data = 64'hBAD0_BAD0_BAD0_BAD0; in_isLast = 1'b1; in_last_bytes = 4'd2;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0; in_isLast = 1'b0; in_last_bytes = '0;
      chk("bp_valid", 64'(blk_valid), 64'd1);
      chk("bp_full", 64'(out_buffer_full), 64'd1);
      chk_blk("bp_data", blk_data, abc_blk);
      if (c == 3) chk("bp_overrun", 64'(in_overrun), 64'd1);
    end
    blk_ready = 1'b1;
    wait_idle("bp");
    chk("bp_overrun_sticky", 64'(in_overrun), 64'd1);

    msg[0] = 64'h0;
    push(empty_blk, 1'b1, 1'b1);
    send_msg(1, 4'd0, 1'b1);
    wait_idle("after_bp");

    // reset in the middle of a message
    for (int i = 0; i < 5; i++) msg[i] = 64'hA5A5_0000_0000_0000 + 64'(i + 1);
    send_msg(5, 4'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_blk("mid_rst_data", blk_data, '0);
    chk("mid_rst_valid", 64'(blk_valid), 64'd0);
    chk("mid_rst_full", 64'(out_buffer_full), 64'd0);
    chk("mid_rst_overrun", 64'(in_overrun), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    msg[0] = 64'h0000_0000_0063_6261;
    push(abc_blk, 1'b1, 1'b1);
    send_msg(1, 4'd3, 1'b1);
    wait_idle("post_rst_abc");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
